disp7seg_scan: RTL and testbench

- Downstream consumer of the stopwatch outputs: takes binary hundredths (0..99) and seconds (0..59) and drives a 4-digit multiplexed 7-segment display in "SS.CC" format.
- Snapshots the inputs once per display frame and converts them to BCD with a small sequential subtract-by-10 engine, so the displayed value never tears mid-frame.
- Scans the digits at a rate set by a parameter; sits between the timing core and the board pins.

---
 rtl/disp7seg_scan.sv | 149 ++++++++++++++
 tb/tb_disp7seg_scan.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/disp7seg_scan.sv
// Four-digit multiplexed 7-segment driver for an "SS.CC" stopwatch readout.
// Inputs are snapshotted once per frame and converted to BCD by repeated subtract-by-10.
module disp7seg_scan #(
   parameter int SCAN_DIV     = 250,
   parameter bit COMMON_ANODE = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] cent_seg,
   input  logic [5:0] seg,
   input  logic       blank_lead,
   output logic [3:0] an,
   output logic [6:0] seg_out,
   output logic       dp,
   output logic       conv_busy
);

   localparam int CW = $clog2(SCAN_DIV);
   localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
   localparam logic [3:0] AN_OFF  = COMMON_ANODE ? 4'hF : 4'h0;
   localparam logic [6:0] SEG_OFF = COMMON_ANODE ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = COMMON_ANODE;

   typedef enum logic {IDLE, CONV} state_t;

   state_t        state;
   logic [CW-1:0] div_cnt;
   logic [1:0]    idx;
   logic          first;
   logic [6:0]    rem_c;
   logic [5:0]    rem_s;
   logic [3:0]    tens_c, tens_s;
   logic          err_c, err_s;
   logic [3:0]    disp_cu, disp_ct, disp_su, disp_st;
   logic          disp_err_c, disp_err_s;

   logic          div_last, frame_start;
   logic [3:0]    val;
   logic          verr;
   logic [6:0]    font, seg_on;
   logic [3:0]    an_on;
   logic          dp_on;

   assign div_last    = (div_cnt == DIV_LAST);
   assign frame_start = first || (div_last && idx == 2'd3);

   always_comb begin
      val  = disp_cu;
      verr = disp_err_c;
      case (idx)
         2'd0: begin val = disp_cu; verr = disp_err_c; end
         2'd1: begin val = disp_ct; verr = disp_err_c; end
         2'd2: begin val = disp_su; verr = disp_err_s; end
         2'd3: begin val = disp_st; verr = disp_err_s; end
         default: ;
      endcase
      case (val)
         4'd0: font = 7'h3F;
         4'd1: font = 7'h06;
         4'd2: font = 7'h5B;
         4'd3: font = 7'h4F;
         4'd4: font = 7'h66;
         4'd5: font = 7'h6D;
         4'd6: font = 7'h7D;
         4'd7: font = 7'h07;
         4'd8: font = 7'h7F;
         4'd9: font = 7'h6F;
         default: font = 7'h00;
      endcase
      // An out-of-range pair shows dash; only a legal zero in the leading digit blanks.
      seg_on = verr ? 7'h40 : font;
      if (idx == 2'd3 && blank_lead && val == 4'd0 && !disp_err_s) seg_on = 7'h00;
      an_on = 4'b0001 << idx;
      dp_on = (idx == 2'd2);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         div_cnt    <= '0;
         idx        <= 2'd0;
         first      <= 1'b1;
         conv_busy  <= 1'b0;
         rem_c      <= '0;
         rem_s      <= '0;
         tens_c     <= '0;
         tens_s     <= '0;
         err_c      <= 1'b0;
         err_s      <= 1'b0;
         disp_cu    <= '0;
         disp_ct    <= '0;
         disp_su    <= '0;
         disp_st    <= '0;
         disp_err_c <= 1'b0;
         disp_err_s <= 1'b0;
         an         <= AN_OFF;
         seg_out    <= SEG_OFF;
         dp         <= DP_OFF;
      end else begin
         first <= 1'b0;
         if (div_last) begin
            div_cnt <= '0;
            idx     <= idx + 2'd1;
         end else begin
            div_cnt <= div_cnt + CW'(1);
         end

         case (state)
            IDLE: if (frame_start) begin
               rem_c     <= cent_seg;
               rem_s     <= seg;
               tens_c    <= '0;
               tens_s    <= '0;
               err_c     <= (cent_seg > 7'd99);
               err_s     <= (seg > 6'd59);
               conv_busy <= 1'b1;
               state     <= CONV;
            end
            CONV: begin
               if (rem_c >= 7'd10) begin
                  rem_c  <= rem_c - 7'd10;
                  tens_c <= tens_c + 4'd1;
               end
               if (rem_s >= 6'd10) begin
                  rem_s  <= rem_s - 6'd10;
                  tens_s <= tens_s + 4'd1;
               end
               // All four digits commit together so a frame never shows a half-updated value.
               if (rem_c < 7'd10 && rem_s < 6'd10) begin
                  disp_cu    <= rem_c[3:0];
                  disp_ct    <= tens_c;
                  disp_su    <= rem_s[3:0];
                  disp_st    <= tens_s;
                  disp_err_c <= err_c;
                  disp_err_s <= err_s;
                  conv_busy  <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         an      <= COMMON_ANODE ? ~an_on  : an_on;
         seg_out <= COMMON_ANODE ? ~seg_on : seg_on;
         dp      <= COMMON_ANODE ? ~dp_on  : dp_on;
      end
   end

endmodule

// File: tb/tb_disp7seg_scan.sv
// Scoreboard bench for disp7seg_scan: stimulus queues cycle-stamped expectations,
// a negedge monitor compares whatever falls due on each cycle.
module tb_disp7seg_scan;

   localparam int DIV = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [6:0] cent_seg;
   logic [5:0] seg;
   logic       blank_lead;
   logic [3:0] an;
   logic [6:0] seg_out;
   logic       dp;
   logic       conv_busy;

   disp7seg_scan #(.SCAN_DIV(DIV), .COMMON_ANODE(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .cent_seg(cent_seg), .seg(seg),
      .blank_lead(blank_lead), .an(an), .seg_out(seg_out), .dp(dp),
      .conv_busy(conv_busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // kind: 0 digit (an/seg/dp), 1 an only, 2 busy only, 3 full inactive state
   typedef struct {
      int         cyc;
      int         kind;
      logic [3:0] an;
      logic [6:0] so;
      logic       dp;
      logic       busy;
      string      name;
   } item_t;

   typedef struct {
      int               c;
      int               s;
      logic             bl;
      logic [3:0][6:0]  ex;   // active-low segment patterns, [d] = digit d
   } vec_t;

   item_t q[$];
   vec_t  vec [10];
   int    checks = 0;
   int    errors = 0;

   always @(negedge clk) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
         if (q[i].cyc <= cyc) begin
            logic bad;
            bad = 1'b0;
            if (q[i].cyc < cyc) bad = 1'b1;
            case (q[i].kind)
               0: bad = bad | (an !== q[i].an) | (seg_out !== q[i].so) | (dp !== q[i].dp);
               1: bad = bad | (an !== q[i].an);
               2: bad = bad | (conv_busy !== q[i].busy);
               default: bad = bad | (an !== q[i].an) | (seg_out !== q[i].so) |
                              (dp !== q[i].dp) | (conv_busy !== q[i].busy);
            endcase
            checks++;
            if (bad) begin
               errors++;
               $display("FAIL %s cyc=%0d got an=%b seg=%h dp=%b busy=%b want an=%b seg=%h dp=%b busy=%b",
                        q[i].name, cyc, an, seg_out, dp, conv_busy,
                        q[i].an, q[i].so, q[i].dp, q[i].busy);
            end
            q.delete(i);
         end
      end
   end

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input int c, input int k, input logic [3:0] a, input logic [6:0] so,
                       input logic d, input logic b, input string nm);
      item_t it;
      it.cyc = c; it.kind = k; it.an = a; it.so = so; it.dp = d; it.busy = b; it.name = nm;
      q.push_back(it);
   endtask

   // Frame m of an epoch whose last reset edge is p: frame start edge, then four 16-cycle digits.
   task automatic push_frame(input int p, input int m, input int v);
      int f, n, st;
      logic [3:0] a;
      f = (m == 0) ? p + 1 : p + 64 * m;
      n = ((vec[v].c / 10) > (vec[v].s / 10) ? (vec[v].c / 10) : (vec[v].s / 10)) + 1;
      push(f,     2, 4'h0, 7'h00, 1'b0, 1'b1, $sformatf("busy_rise_v%0d", v));
      push(f + n, 2, 4'h0, 7'h00, 1'b0, 1'b0, $sformatf("busy_fall_v%0d", v));
      for (int d = 0; d < 4; d++) begin
         st = p + 1 + 64 * m + 16 * d;
         a  = ~(4'b0001 << d);
         push(st, 1, a, 7'h00, 1'b0, 1'b0, $sformatf("an_first_v%0d_d%0d", v, d));
         push(st + DIV - 1, 0, a, vec[v].ex[d], (d == 2) ? 1'b0 : 1'b1, 1'b0,
              $sformatf("digit_v%0d_d%0d", v, d));
      end
   endtask

   task automatic setv(input int i, input int c, input int s, input logic bl,
                       input logic [6:0] e0, input logic [6:0] e1,
                       input logic [6:0] e2, input logic [6:0] e3);
      vec[i].c = c; vec[i].s = s; vec[i].bl = bl;
      vec[i].ex[0] = e0; vec[i].ex[1] = e1; vec[i].ex[2] = e2; vec[i].ex[3] = e3;
   endtask

   initial begin
      int p, f;
      //        cent sec  bl   d0     d1     d2     d3
      setv(0,   0,   0,  0, 7'h40, 7'h40, 7'h40, 7'h40);
      setv(1,  47,  35,  0, 7'h78, 7'h19, 7'h12, 7'h30);
      setv(2,   9,   5,  1, 7'h10, 7'h40, 7'h12, 7'h7F);
      setv(3,   9,   5,  0, 7'h10, 7'h40, 7'h12, 7'h40);
      setv(4,  12,   0,  0, 7'h24, 7'h79, 7'h40, 7'h40);
      setv(5,  88,   0,  1, 7'h00, 7'h00, 7'h40, 7'h7F);
      setv(6, 120,  63,  1, 7'h3F, 7'h3F, 7'h3F, 7'h3F);
      setv(7,  99,  59,  0, 7'h10, 7'h10, 7'h10, 7'h12);
      setv(8,  99,  59,  0, 7'h10, 7'h10, 7'h10, 7'h12);
      setv(9,  30,  42,  0, 7'h40, 7'h30, 7'h24, 7'h19);

      rst_n      = 1'b0;
      cent_seg   = 7'(vec[0].c);
      seg        = 6'(vec[0].s);
      blank_lead = vec[0].bl;
      for (int c = 1; c <= 3; c++)
         push(c, 3, 4'hF, 7'h7F, 1'b1, 1'b0, $sformatf("reset_state_c%0d", c));
      wait_cyc(3);
      rst_n = 1'b1;
      p = 3;

      for (int m = 0; m < 8; m++) begin
         f = (m == 0) ? p + 1 : p + 64 * m;
         wait_cyc(f - 1);
         push_frame(p, m, m);
         wait_cyc(f);
         blank_lead = vec[m].bl;
         // Next frame's values arrive mid-frame and must not disturb this one.
         wait_cyc(f + 20);
         cent_seg = 7'(vec[m + 1].c);
         seg      = 6'(vec[m + 1].s);
      end

      // Abort a conversion in flight with a one-cycle reset.
      f = p + 64 * 8;
      wait_cyc(f - 1);
      push(f, 2, 4'h0, 7'h00, 1'b0, 1'b1, "busy_before_abort");
      wait_cyc(f + 3);
      rst_n      = 1'b0;
      cent_seg   = 7'(vec[9].c);
      seg        = 6'(vec[9].s);
      blank_lead = vec[9].bl;
      push(f + 4, 3, 4'hF, 7'h7F, 1'b1, 1'b0, "abort_reset_state");
      wait_cyc(f + 4);
      rst_n = 1'b1;
      p = f + 4;
      push_frame(p, 0, 9);

      wait_cyc(p + 70);
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
